// File: rtl/estagio_busca_pkg.sv
// Shared definitions for the pipelined RISC-V fetch stage and its pipeline registers.
package estagio_busca_pkg;

  localparam int unsigned LARGURA = 32;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } estado_t;

endpackage

// File: rtl/estagio_busca_if.sv
// Instruction-memory port: valid/ready request channel plus a valid-only response channel.
interface estagio_busca_if #(
  parameter int unsigned LARGURA = estagio_busca_pkg::LARGURA
);

  logic               imem_req_valid;
  logic [LARGURA-1:0] imem_req_addr;
  logic               imem_req_ready;
  logic               imem_rsp_valid;
  logic [LARGURA-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/estagio_busca_reg_if_id.sv
// IF/ID pipeline register: clr drops the held entry, en loads a new one.
module reg_if_id #(
  parameter int unsigned LARGURA = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [LARGURA-1:0] instr_d,
  input  logic [LARGURA-1:0] pc_d,
  input  logic [LARGURA-1:0] pc4_d,
  output logic               valid,
  output logic [LARGURA-1:0] instr,
  output logic [LARGURA-1:0] pc,
  output logic [LARGURA-1:0] pc4
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
      pc4   <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (en) begin
      valid <= 1'b1;
      instr <= instr_d;
      pc    <= pc_d;
      pc4   <= pc4_d;
    end
  end

endmodule

// File: rtl/estagio_busca.sv
// Fetch stage: owns the PC, keeps one fetch in flight and feeds decode via IF/ID.
module estagio_busca #(
  parameter int unsigned        LARGURA  = estagio_busca_pkg::LARGURA,
  parameter logic [LARGURA-1:0] PC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  estagio_busca_if.master    imem,
  input  logic               redirect_valid,
  input  logic [LARGURA-1:0] redirect_pc,
  output logic               if_id_valid,
  output logic [LARGURA-1:0] if_id_instr,
  output logic [LARGURA-1:0] if_id_pc,
  output logic [LARGURA-1:0] if_id_pc4,
  input  logic               id_ready
);

  import estagio_busca_pkg::*;

  localparam logic [LARGURA-1:0] QUATRO = LARGURA'(4);

  estado_t            estado;
  logic [LARGURA-1:0] pc;
  logic [LARGURA-1:0] pc_voo;
  logic [LARGURA-1:0] buf_instr;
  logic [LARGURA-1:0] buf_pc;
  logic               descarta;

  logic               carrega_rsp;
  logic               carrega_buf;
  logic               reg_en;
  logic               reg_clr;
  logic [LARGURA-1:0] d_instr;
  logic [LARGURA-1:0] d_pc;

  assign imem.imem_req_valid = (estado == S_REQ) && !rst;
  assign imem.imem_req_addr  = pc;

  always_comb begin
    carrega_rsp = (estado == S_WAIT) && imem.imem_rsp_valid && !descarta &&
                  (!if_id_valid || id_ready);
    carrega_buf = (estado == S_FULL) && id_ready;
    reg_en      = !redirect_valid && (carrega_rsp || carrega_buf);
    // Consumption with nothing new to load empties the register.
    reg_clr     = redirect_valid || (if_id_valid && id_ready && !reg_en);
    d_instr     = carrega_buf ? buf_instr : imem.imem_rsp_data;
    d_pc        = carrega_buf ? buf_pc : pc_voo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado    <= S_REQ;
      pc        <= PC_RESET;
      pc_voo    <= '0;
      descarta  <= 1'b0;
      buf_instr <= '0;
      buf_pc    <= '0;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[LARGURA-1:2], 2'b00};
      // An accepted-but-unanswered fetch must have its word dropped later.
      case (estado)
        S_REQ: begin
          estado   <= imem.imem_req_ready ? S_WAIT : S_REQ;
          descarta <= imem.imem_req_ready;
        end
        S_WAIT: begin
          estado   <= imem.imem_rsp_valid ? S_REQ : S_WAIT;
          descarta <= !imem.imem_rsp_valid;
        end
        default: begin
          estado   <= S_REQ;
          descarta <= 1'b0;
        end
      endcase
    end else begin
      case (estado)
        S_REQ: begin
          if (imem.imem_req_ready) begin
            pc_voo <= pc;
            pc     <= pc + QUATRO;
            estado <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (descarta) begin
              descarta <= 1'b0;
              estado   <= S_REQ;
            end else if (!if_id_valid || id_ready) begin
              estado <= S_REQ;
            end else begin
              buf_instr <= imem.imem_rsp_data;
              buf_pc    <= pc_voo;
              estado    <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (id_ready) estado <= S_REQ;
        end
        default: estado <= S_REQ;
      endcase
    end
  end

  reg_if_id #(
    .LARGURA (LARGURA)
  ) u_reg_if_id (
    .clk     (clk),
    .rst     (rst),
    .en      (reg_en),
    .clr     (reg_clr),
    .instr_d (d_instr),
    .pc_d    (d_pc),
    .pc4_d   (d_pc + QUATRO),
    .valid   (if_id_valid),
    .instr   (if_id_instr),
    .pc      (if_id_pc),
    .pc4     (if_id_pc4)
  );

endmodule

// File: tb/tb_estagio_busca.sv
// Scoreboard bench for estagio_busca: a memory model and an IF/ID monitor check queued expectations.
module tb_estagio_busca;
  import estagio_busca_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4;

  logic        rst2 = 1'b1;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;
  logic        id_ready2 = 1'b1;
  logic        if_id_valid2;
  logic [31:0] if_id_instr2, if_id_pc2, if_id_pc42;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  int          acc_cnt = 0;
  int          rel = 0;

  logic [31:0] req_q[$];
  ent_t        ifid_q[$];
  int          pop_cyc[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  estagio_busca_if #(.LARGURA(32)) mem_if ();
  estagio_busca_if #(.LARGURA(32)) mem_if2 ();

  estagio_busca #(.LARGURA(32), .PC_RESET(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (mem_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .id_ready       (id_ready)
  );

  estagio_busca #(.LARGURA(32), .PC_RESET(32'hFFFF_FFFC)) dut2 (
    .clk            (clk),
    .rst            (rst2),
    .imem           (mem_if2),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (redirect_pc2),
    .if_id_valid    (if_id_valid2),
    .if_id_instr    (if_id_instr2),
    .if_id_pc       (if_id_pc2),
    .if_id_pc4      (if_id_pc42),
    .id_ready       (id_ready2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nome, got, exp);
    end
  endtask

  task automatic timeout(input string nome);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", nome);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_req(input logic [31:0] a);
    req_q.push_back(a);
  endtask

  task automatic push_ifid(input logic [31:0] a);
    ifid_q.push_back('{pc: a, pc4: a + 32'd4, instr: mem_word(a)});
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (acc_cnt < n && k < 60) begin
      tick();
      k++;
    end
    if (acc_cnt < n) timeout("wait_acc");
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!if_id_valid && k < 30) begin
      tick();
      k++;
    end
    if (!if_id_valid) timeout("wait_valid");
  endtask

  task automatic drain(input string nome);
    int k = 0;
    while ((req_q.size() != 0 || ifid_q.size() != 0) && k < 60) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check({nome, "_req_left"}, req_q.size(), 0);
    check({nome, "_ifid_left"}, ifid_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    check("rst_req_valid", mem_if.imem_req_valid, 0);
    check("rst_req_addr", mem_if.imem_req_addr, 32'h0);
    check("rst_if_id_valid", if_id_valid, 0);
    check("rst_if_id_instr", if_id_instr, 0);
    check("rst_if_id_pc", if_id_pc, 0);
    check("rst_if_id_pc4", if_id_pc4, 0);
    req_q.delete();
    ifid_q.delete();
    pop_cyc.delete();
    acc_cnt = 0;
    rst = 1'b0;
    rel = cyc;
  endtask

  // Memory model: accepts requests, answers after 'lat' cycles, checks request addresses.
  initial begin
    mem_if.imem_rsp_valid = 1'b0;
    mem_if.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      mem_if.imem_rsp_valid = 1'b0;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
      end else begin
        if (pend_due.size() != 0 && pend_due[0] == cyc) begin
          mem_if.imem_rsp_valid = 1'b1;
          mem_if.imem_rsp_data  = mem_word(pend_addr[0]);
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        if (mem_if.imem_req_valid && mem_if.imem_req_ready) begin
          acc_cnt++;
          pend_addr.push_back(mem_if.imem_req_addr);
          pend_due.push_back(cyc + lat);
          if (req_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL req_unexpected: got %h expected none", mem_if.imem_req_addr);
          end else begin
            check("req_addr", mem_if.imem_req_addr, req_q.pop_front());
          end
        end
      end
    end
  end

  // IF/ID monitor: every consumed entry must match the head of the expected queue.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst && if_id_valid && id_ready) begin
        pop_cyc.push_back(cyc);
        if (ifid_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL ifid_unexpected: got pc %h expected none", if_id_pc);
        end else begin
          e = ifid_q.pop_front();
          check("ifid_pc", if_id_pc, e.pc);
          check("ifid_pc4", if_id_pc4, e.pc4);
          check("ifid_instr", if_id_instr, e.instr);
        end
      end
    end
  end

  // Second memory: always ready, fixed one-cycle latency.
  initial begin
    logic        acc2;
    logic [31:0] addr2;
    acc2  = 1'b0;
    addr2 = '0;
    mem_if2.imem_req_ready = 1'b1;
    mem_if2.imem_rsp_valid = 1'b0;
    mem_if2.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      mem_if2.imem_rsp_valid = acc2 && !rst2;
      mem_if2.imem_rsp_data  = mem_word(addr2);
      acc2  = !rst2 && mem_if2.imem_req_valid && mem_if2.imem_req_ready;
      addr2 = mem_if2.imem_req_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    mem_if.imem_req_ready = 1'b0;

    // 1: streaming at the two-cycle cadence
    lat = 1;
    mem_if.imem_req_ready = 1'b1;
    id_ready = 1'b1;
    do_reset();
    push_req(32'h0); push_req(32'h4); push_req(32'h8);
    push_ifid(32'h0); push_ifid(32'h4); push_ifid(32'h8);
    wait_acc(3);
    mem_if.imem_req_ready = 1'b0;
    drain("s1");
    if (pop_cyc.size() >= 3) begin
      check("s1_first_latency", pop_cyc[0], rel + 2);
      check("s1_cadence_a", pop_cyc[1] - pop_cyc[0], 2);
      check("s1_cadence_b", pop_cyc[2] - pop_cyc[1], 2);
    end else begin
      timeout("s1_pop_count");
    end

    // 2: backpressure fills the hold buffer
    mem_if.imem_req_ready = 1'b1;
    id_ready = 1'b0;
    do_reset();
    push_req(32'h0); push_req(32'h4); push_req(32'h8);
    push_ifid(32'h0); push_ifid(32'h4); push_ifid(32'h8);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("s2_hold_valid", if_id_valid, 1);
      check("s2_hold_pc", if_id_pc, 32'h0);
      if (i == 4) begin
        check("s2_no_req", mem_if.imem_req_valid, 0);
        check("s2_state_full", 32'(dut.estado), 32'(S_FULL));
      end
      tick();
    end
    id_ready = 1'b1;
    tick();
    check("s2_buf_valid", if_id_valid, 1);
    check("s2_buf_pc", if_id_pc, 32'h4);
    check("s2_next_req_valid", mem_if.imem_req_valid, 1);
    check("s2_next_req_addr", mem_if.imem_req_addr, 32'h8);
    wait_acc(3);
    mem_if.imem_req_ready = 1'b0;
    drain("s2");

    // 3: redirect while a 3-cycle fetch is outstanding
    lat = 3;
    mem_if.imem_req_ready = 1'b1;
    id_ready = 1'b1;
    do_reset();
    push_req(32'h0); push_req(32'h4); push_req(32'h8); push_req(32'hC);
    push_req(32'h10); push_req(32'h100);
    push_ifid(32'h0); push_ifid(32'h4); push_ifid(32'h8); push_ifid(32'hC);
    push_ifid(32'h100);
    wait_acc(5);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check("s3_state_wait", 32'(dut.estado), 32'(S_WAIT));
    check("s3_descarta", dut.descarta, 1);
    wait_acc(6);
    mem_if.imem_req_ready = 1'b0;
    drain("s3");

    // 4: redirect on a response edge while IF/ID is stalled
    lat = 1;
    mem_if.imem_req_ready = 1'b1;
    id_ready = 1'b0;
    do_reset();
    push_req(32'h0); push_req(32'h4); push_req(32'h40);
    push_ifid(32'h40);
    wait_valid();
    tick();
    check("s4_pre_valid", if_id_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    check("s4_flush_valid", if_id_valid, 0);
    check("s4_state_req", 32'(dut.estado), 32'(S_REQ));
    check("s4_req_addr", mem_if.imem_req_addr, 32'h40);
    id_ready = 1'b1;
    wait_acc(3);
    mem_if.imem_req_ready = 1'b0;
    drain("s4");

    // 5: PC wraps from the top of the address space
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    #1;
    check("s5_first_req_valid", mem_if2.imem_req_valid, 1);
    check("s5_first_req_addr", mem_if2.imem_req_addr, 32'hFFFF_FFFC);
    k = 0;
    while (!if_id_valid2 && k < 20) begin
      tick();
      k++;
    end
    if (!if_id_valid2) timeout("s5_wait_valid");
    check("s5_pc", if_id_pc2, 32'hFFFF_FFFC);
    check("s5_pc4", if_id_pc42, 32'h0000_0000);
    check("s5_instr", if_id_instr2, mem_word(32'hFFFF_FFFC));
    check("s5_second_req_valid", mem_if2.imem_req_valid, 1);
    check("s5_second_req_addr", mem_if2.imem_req_addr, 32'h0);
    rst2 = 1'b1;

    // 6a: reset while a fetch is outstanding
    lat = 3;
    mem_if.imem_req_ready = 1'b1;
    id_ready = 1'b1;
    do_reset();
    push_req(32'h0);
    tick();
    check("s6a_state_wait", 32'(dut.estado), 32'(S_WAIT));
    rst = 1'b1;
    tick();
    acc_cnt = 0;
    rst = 1'b0;
    #1;
    check("s6a_valid", if_id_valid, 0);
    check("s6a_state", 32'(dut.estado), 32'(S_REQ));
    check("s6a_req_valid", mem_if.imem_req_valid, 1);
    check("s6a_req_addr", mem_if.imem_req_addr, 32'h0);
    push_req(32'h0);
    push_ifid(32'h0);
    wait_acc(1);
    mem_if.imem_req_ready = 1'b0;
    drain("s6a");

    // 6b: reset while the hold buffer is full
    lat = 1;
    mem_if.imem_req_ready = 1'b1;
    id_ready = 1'b0;
    do_reset();
    push_req(32'h0); push_req(32'h4);
    k = 0;
    while (dut.estado != S_FULL && k < 20) begin
      tick();
      k++;
    end
    if (dut.estado != S_FULL) timeout("s6b_wait_full");
    rst = 1'b1;
    tick();
    acc_cnt = 0;
    rst = 1'b0;
    #1;
    check("s6b_valid", if_id_valid, 0);
    check("s6b_state", 32'(dut.estado), 32'(S_REQ));
    check("s6b_req_valid", mem_if.imem_req_valid, 1);
    check("s6b_req_addr", mem_if.imem_req_addr, 32'h0);
    push_req(32'h0); push_req(32'h4);
    push_ifid(32'h0); push_ifid(32'h4);
    id_ready = 1'b1;
    wait_acc(2);
    mem_if.imem_req_ready = 1'b0;
    drain("s6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
